// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - warm/cold system reset sequencer with optional RAM zero-fill sweep
// Optional RAM clear sweep is built only when RESET_SEQUENCER_COLD_CLEAR_EN is defined.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int CLR_ADDR_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  reset_req_cold,
    output logic                  sys_reset,
    output logic                  clr_wren,
    output logic [CLR_ADDR_W-1:0] clr_addr,
    input  logic                  clr_ack,
    output logic                  cold_flag
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]       HC_LAST   = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CLR_ADDR_W-1:0] ADDR_LAST = '1;

`ifdef RESET_SEQUENCER_COLD_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Power-on is treated as a cold request, so it lands where a cold request would.
    localparam state_t ST_POR = CLR_EN ? ST_CLEAR : ST_HOLD;

    state_t                state_q,    state_d;
    logic [HC_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [CLR_ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic                  cold_flag_q, cold_flag_d;
    logic                  cold_req;

    // Next-state decode: cold requests pre-empt ack and hold completion; warm requests only restart HOLD.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        clr_addr_d  = clr_addr_q;
        cold_flag_d = cold_flag_q;
        cold_req    = CLR_EN && reset_req && reset_req_cold;

        unique case (state_q)
            ST_IDLE: begin
                if (reset_req) begin
                    cold_flag_d = reset_req_cold;
                    if (cold_req) begin
                        state_d    = ST_CLEAR;
                        clr_addr_d = '0;
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            ST_CLEAR: begin
                if (cold_req) begin
                    clr_addr_d  = '0;
                    cold_flag_d = 1'b1;
                end else if (clr_ack) begin
                    if (clr_addr_q == ADDR_LAST) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cold_req) begin
                    state_d     = ST_CLEAR;
                    clr_addr_d  = '0;
                    cold_flag_d = 1'b1;
                end else if (reset_req) begin
                    // Without the clear sweep a cold request degenerates to a restart but is still recorded.
                    hold_cnt_d = '0;
                    if (reset_req_cold) begin
                        cold_flag_d = 1'b1;
                    end
                end else if (hold_cnt_q == HC_LAST) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; power-on reset dominates every request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_POR;
            hold_cnt_q  <= '0;
            clr_addr_q  <= '0;
            cold_flag_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            clr_addr_q  <= clr_addr_d;
            cold_flag_q <= cold_flag_d;
        end
    end

    assign sys_reset = (state_q != ST_IDLE);
    assign clr_wren  = CLR_EN && (state_q == ST_CLEAR);
    assign clr_addr  = CLR_EN ? clr_addr_q : '0;
    assign cold_flag = cold_flag_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    localparam int HOLD = 16;
`ifdef RESET_SEQUENCER_COLD_CLEAR_EN
    localparam int CLR_N = 16;
`else
    localparam int CLR_N = 0;
`endif
    localparam bit CLR_EN = (CLR_N != 0);

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_req;
    logic       reset_req_cold;
    logic       sys_reset;
    logic       clr_wren;
    logic [3:0] clr_addr;
    logic       clr_ack;
    logic       cold_flag;

    int n_checks = 0;
    int n_pass   = 0;

    reset_sequencer #(
        .HOLD_CYCLES(HOLD),
        .CLR_ADDR_W (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reset_req     (reset_req),
        .reset_req_cold(reset_req_cold),
        .sys_reset     (sys_reset),
        .clr_wren      (clr_wren),
        .clr_addr      (clr_addr),
        .clr_ack       (clr_ack),
        .cold_flag     (cold_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic req;
        logic cold;
        logic ack;
        int   wait_n;
        logic e_sr;
        logic e_wren;
        int   e_addr;
        bit   chk_a;
        logic e_cf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic a, int w, logic sr, logic wr,
                                int ad, bit ca, logic cf);
        vec_t v;
        v = '{r, c, a, w, sr, wr, ad, ca, cf};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_outs(input string tag, input logic e_sr, input logic e_wren,
                            input int e_addr, input bit chk_a, input logic e_cf);
        check({tag, ".sys_reset"}, int'(sys_reset), int'(e_sr));
        check({tag, ".clr_wren"},  int'(clr_wren),  int'(e_wren));
        check({tag, ".cold_flag"}, int'(cold_flag), int'(e_cf));
        if (chk_a) check({tag, ".clr_addr"}, int'(clr_addr), e_addr);
    endtask

    // Pulse a request, optionally inject a second event at high-cycle inj_n, and measure sys_reset length.
    task automatic run_seq(input string tag, input logic init_cold, input int inj_n,
                           input logic inj_req, input logic inj_cold, input logic inj_rst,
                           input bit chk_post, input int exp_len);
        int n;
        reset_req = 1'b1; reset_req_cold = init_cold; clr_ack = 1'b1;
        tick();
        reset_req = 1'b0; reset_req_cold = 1'b0;
        n = 0;
        while (sys_reset && n < 400) begin
            n++;
            if (n == inj_n) begin
                reset_req = inj_req; reset_req_cold = inj_cold; reset = inj_rst;
            end
            tick();
            reset_req = 1'b0; reset_req_cold = 1'b0; reset = 1'b0;
            if (n == inj_n && chk_post) chk_outs({tag, "_post"}, 1'b1, CLR_EN, 0, 1'b1, 1'b1);
        end
        check({tag, ".len"}, n, exp_len);
    endtask

    initial begin
        int n;

        // Power-on: three reset cycles, then clear sweep and hold.
        reset = 1'b1; reset_req = 1'b0; reset_req_cold = 1'b0; clr_ack = 1'b1;
        repeat (3) tick();
        chk_outs("por_in_reset", 1'b1, CLR_EN, 0, 1'b1, 1'b1);
        reset = 1'b0;
        n = 0;
        while (sys_reset && n < 400) begin
            if (n < CLR_N) begin
                check($sformatf("por_addr%0d", n), int'(clr_addr), n);
                check($sformatf("por_wren%0d", n), int'(clr_wren), 1);
            end else begin
                check($sformatf("por_wren%0d", n), int'(clr_wren), 0);
            end
            n++;
            tick();
        end
        check("por.len", n, CLR_N + HOLD);
        check("por.cold_flag", int'(cold_flag), 1);

        // Table-driven vectors starting from IDLE with cold_flag=1.
        vecs.push_back(mk(1, 1, 1, 1, 1, CLR_EN, 0, 1, 1));
`ifdef RESET_SEQUENCER_COLD_CLEAR_EN
        vecs.push_back(mk(0, 0, 1, 7, 1, 1, 7, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8, 1, 1, 15, 1, 1));
        vecs.push_back(mk(0, 0, 1, 16, 1, 0, 0, 0, 1));
`else
        vecs.push_back(mk(0, 0, 1, 15, 1, 0, 0, 1, 1));
`endif
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 15, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4, 0, 0, 0, 1, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            reset_req = vecs[i].req; reset_req_cold = vecs[i].cold; clr_ack = vecs[i].ack;
            tick();
            reset_req = 1'b0; reset_req_cold = 1'b0;
            for (int k = 1; k < vecs[i].wait_n; k++) tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_sr, vecs[i].e_wren, vecs[i].e_addr,
                     vecs[i].chk_a, vecs[i].e_cf);
        end

        // Cold request with clr_ack low on every other cycle.
        reset_req = 1'b1; reset_req_cold = 1'b1; clr_ack = 1'b0;
        tick();
        reset_req = 1'b0; reset_req_cold = 1'b0;
        n = 0;
        while (sys_reset && n < 400) begin
            n++;
            if (n <= 2 * CLR_N) begin
                check($sformatf("stall_wren%0d", n), int'(clr_wren), 1);
                check($sformatf("stall_addr%0d", n), int'(clr_addr), (n - 1) / 2);
            end else begin
                check($sformatf("stall_wren%0d", n), int'(clr_wren), 0);
            end
            clr_ack = (n % 2 == 0);
            tick();
        end
        clr_ack = 1'b1;
        check("stall.len", n, 2 * CLR_N + HOLD);
        check("stall.cold_flag", int'(cold_flag), 1);

        // Multi-cycle corner cases.
        run_seq("warm_restart", 1'b0, 11, 1'b1, 1'b0, 1'b0, 1'b0, 11 + HOLD);
        check("warm_restart.cold_flag", int'(cold_flag), 0);
        run_seq("cold_in_hold", 1'b1, CLR_N + 6, 1'b1, 1'b1, 1'b0, 1'b1, CLR_N + 6 + CLR_N + HOLD);
        run_seq("warm_in_clear", 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0,
                CLR_EN ? (CLR_N + HOLD) : (8 + HOLD));
        run_seq("reset_in_clear", 1'b1, 6, 1'b0, 1'b0, 1'b1, 1'b1, 6 + CLR_N + HOLD);
        chk_outs("final_idle", 1'b0, 1'b0, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
